if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch32 pipeline (IF/ID/EXE/MEM/WB). It replaces the single-cycle fetch path.
- Owns the PC and drives the synchronous instruction SRAM, which has 1-cycle read latency.
- Delivers {pc, inst} to the decode stage over a valid/allowin handshake.
- Accepts branch redirects from decode. Holds a 1-entry instruction buffer so that the SRAM read data survives decode back-pressure.

---
 rtl/cpu_defs.sv | 30 +++
 rtl/if_stage.sv | 80 ++++++++
 tb/tb_if_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline definitions: bus widths, field offsets and reset PC.
package cpu_defs;

    localparam int unsigned FS_TO_DS_BUS_WD = 64;
    localparam int unsigned BR_BUS_WD       = 33;

    localparam logic [31:0] RESET_PC = 32'h1bfffffc;

    // br_bus fields
    localparam int unsigned BR_TAKEN_BIT  = 32;
    localparam int unsigned BR_TARGET_MSB = 31;
    localparam int unsigned BR_TARGET_LSB = 0;

    // fs_to_ds_bus fields
    localparam int unsigned FS_PC_MSB   = 63;
    localparam int unsigned FS_PC_LSB   = 32;
    localparam int unsigned FS_INST_MSB = 31;
    localparam int unsigned FS_INST_LSB = 0;

    // Pack the IF->ID payload in field order.
    function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_to_ds(input logic [31:0] pc,
                                                                 input logic [31:0] inst);
        logic [FS_TO_DS_BUS_WD-1:0] bus;
        bus                          = '0;
        bus[FS_PC_MSB:FS_PC_LSB]     = pc;
        bus[FS_INST_MSB:FS_INST_LSB] = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction SRAM,
// and hands {pc, inst} to decode with a 1-entry buffer for decode back-pressure.
module if_stage
    import cpu_defs::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic                       inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] fs_inst;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;

    // Pre-IF address generation and IF handshake.
    always_comb begin
        br_taken        = br_bus[BR_TAKEN_BIT];
        br_target       = br_bus[BR_TARGET_MSB:BR_TARGET_LSB];
        to_fs_valid     = ~reset;
        seq_pc          = fs_pc + 32'd4;
        nextpc          = br_taken ? br_target : seq_pc;
        fs_ready_go     = 1'b1;
        fs_allowin      = ~fs_valid | (fs_ready_go & ds_allowin);
        fs_to_ds_valid  = fs_valid & fs_ready_go & ~br_taken;
        // Buffered word wins: SRAM output is stale once a stall has lasted a cycle.
        fs_inst         = inst_buf_valid ? inst_buf : inst_sram_rdata;
        fs_to_ds_bus    = pack_fs_to_ds(fs_pc, fs_inst);
        inst_sram_en    = to_fs_valid & fs_allowin;
        inst_sram_we    = 1'b0;
        inst_sram_addr  = nextpc;
        inst_sram_wdata = 32'd0;
    end

    // PC and valid bit advance whenever a new fetch is accepted into IF.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC;
        end else begin
            if (fs_allowin) begin
                fs_valid <= to_fs_valid;
            end
            if (to_fs_valid && fs_allowin) begin
                fs_pc <= nextpc;
            end
        end
    end

    // Hold the SRAM word on the first stall cycle; drop it on delivery or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf       <= 32'd0;
            inst_buf_valid <= 1'b0;
        end else if ((fs_to_ds_valid && ds_allowin) || br_taken) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid && !inst_buf_valid && !ds_allowin) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table plus randomized run
// against a fetch-stream reference model.
module tb_if_stage;
    import cpu_defs::*;

    logic                       clk;
    logic                       reset;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic                       inst_sram_we;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    int checks;
    int errors;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at byte address a is 0x02800000 + word index from 0x1c000000.
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h1c000000;
        return 32'h02800000 + (off >> 2);
    endfunction

    // SRAM with 1-cycle latency; un-requested cycles return garbage.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? word(inst_sram_addr) : 32'hdeadbeef;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic rst, input logic allow, input logic br,
                         input logic [31:0] tgt);
        @(negedge clk);
        reset      = rst;
        ds_allowin = allow;
        br_bus     = {br, tgt};
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        allow;
        logic        br;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic allow, input logic br,
                                input logic [31:0] tgt, input logic en,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.allow = allow; v.br = br; v.tgt = tgt;
        v.en = en; v.addr = addr; v.valid = valid; v.pc = pc;
        return v;
    endfunction

    // Reference model state: at most one instruction sits in IF.
    logic        m_valid;
    logic [31:0] m_pc;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        ds_allowin = 1'b1;
        br_bus = '0;

        // Power-up reset.
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check("reset_en0", {31'd0, inst_sram_en}, 32'd0);
        apply(1'b1, 1'b1, 1'b0, 32'h0);
        check("reset_en1", {31'd0, inst_sram_en}, 32'd0);
        check("reset_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        check("reset_addr", inst_sram_addr, 32'h1c000000);
        check("tied_we", {31'd0, inst_sram_we}, 32'd0);
        check("tied_wdata", inst_sram_wdata, 32'd0);

        //             rst   allow br    tgt            en    addr           valid pc
        // startup and steady flow
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000000, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000004, 1'b1, 32'h1c000000));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000008, 1'b1, 32'h1c000004));
        // 3-cycle stall on pc 08, then release
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c00000c, 1'b1, 32'h1c000008));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c00000c, 1'b1, 32'h1c000008));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000010, 1'b1, 32'h1c00000c));
        // branch cancels pc 10
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h1c000100, 1'b1, 32'h1c000100, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000104, 1'b1, 32'h1c000100));
        // stall fills buffer, then branch drops it
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000108, 1'b1, 32'h1c000104));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000108, 1'b1, 32'h1c000104));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h1c000200, 1'b1, 32'h1c000200, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000204, 1'b1, 32'h1c000200));
        // reset during a stall with the buffer full
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000208, 1'b1, 32'h1c000204));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000208, 1'b1, 32'h1c000204));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1c000208, 1'b1, 32'h1c000204));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000000, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000004, 1'b1, 32'h1c000000));
        // PC wrap
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'hfffffffc, 1'b1, 32'hfffffffc, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 32'hfffffffc));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00000004, 1'b1, 32'h00000000));
        // branch while IF is empty
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00000008, 1'b1, 32'h00000004));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h1c000040, 1'b1, 32'h1c000040, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1c000044, 1'b1, 32'h1c000040));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].allow, vecs[i].br, vecs[i].tgt);
            check($sformatf("vec%0d_en", i), {31'd0, inst_sram_en}, {31'd0, vecs[i].en});
            check($sformatf("vec%0d_addr", i), inst_sram_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), {31'd0, fs_to_ds_valid}, {31'd0, vecs[i].valid});
            if (vecs[i].valid) begin
                check($sformatf("vec%0d_pc", i), fs_to_ds_bus[63:32], vecs[i].pc);
                check($sformatf("vec%0d_inst", i), fs_to_ds_bus[31:0], word(vecs[i].pc));
            end
        end

        // Randomized run against the fetch-stream model.
        m_valid = 1'b0;
        m_pc    = RESET_PC;
        for (int i = 0; i < 3000; i++) begin
            logic        rst;
            logic        allow;
            logic        br;
            logic [31:0] tgt;
            logic        e_en;
            logic [31:0] e_addr;
            logic        e_valid;
            rst   = (i == 0) || ($urandom_range(0, 99) == 0);
            allow = ($urandom_range(0, 2) != 0);
            br    = allow && ($urandom_range(0, 7) == 0);
            tgt   = ($urandom_range(0, 15) == 0) ? 32'hfffffffc
                                                 : 32'h1c000000 + ($urandom_range(0, 1023) << 2);
            apply(rst, allow, br, br ? tgt : 32'h0);

            e_en    = !rst && (!m_valid || allow);
            e_addr  = br ? tgt : m_pc + 32'd4;
            e_valid = m_valid && !br;
            check("rnd_en", {31'd0, inst_sram_en}, {31'd0, e_en});
            if (i > 0) begin
                check("rnd_addr", inst_sram_addr, e_addr);
                check("rnd_valid", {31'd0, fs_to_ds_valid}, {31'd0, e_valid});
                if (e_valid) begin
                    check("rnd_pc", fs_to_ds_bus[63:32], m_pc);
                    check("rnd_inst", fs_to_ds_bus[31:0], word(m_pc));
                end
            end

            if (rst) begin
                m_valid = 1'b0;
                m_pc    = RESET_PC;
            end else if (e_en) begin
                m_valid = 1'b1;
                m_pc    = e_addr;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
